pm_accum: RTL and testbench

PM_ACCUM -- requirements
Module: pm_accum

---
 rtl/pm_accum_if.sv | 24 ++
 rtl/pm_accum.sv | 108 ++++++++++
 tb/tb_pm_accum.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pm_accum_if.sv
// Product-in / result-out handshake bundle for pm_accum.
// master is the surrounding pipeline, slave is the accumulator.
interface pm_accum_if #(
  parameter int unsigned ACC_W = 12
);
  logic [7:0]       prod_in;
  logic             prod_valid;
  logic             prod_ready;
  logic             clear;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             out_ready;
  logic             sat;

  modport master (
    output prod_in, prod_valid, clear, out_ready,
    input  prod_ready, acc_out, acc_valid, sat
  );

  modport slave (
    input  prod_in, prod_valid, clear, out_ready,
    output prod_ready, acc_out, acc_valid, sat
  );
endinterface

// File: rtl/pm_accum.sv
// Saturating accumulator: sums LEN unsigned 8-bit products and presents each total
// with a valid/ready handshake.
module pm_accum #(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned LEN   = 4
) (
  input logic      clk,
  input logic      rst_n,
  pm_accum_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  localparam logic [3:0] LenC = 4'(LEN);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] prod_ext;

  assign prod_ext = {{(ACC_W - 8){1'b0}}, bus.prod_in};
  // One spare MSB catches the carry that signals saturation.
  assign sum_ext  = {1'b0, acc_q} + {1'b0, prod_ext};

  assign bus.prod_ready = (state_q != StHold) || bus.out_ready;
  assign accept         = bus.prod_valid && bus.prod_ready;

  assign bus.acc_out    = acc_q;
  assign bus.acc_valid  = (state_q == StHold);
  assign bus.sat        = sat_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    if (bus.clear) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            acc_d   = prod_ext;
            cnt_d   = 4'd1;
            state_d = (LEN == 1) ? StHold : StAccum;
          end
        end
        StAccum: begin
          if (accept) begin
            if (sum_ext[ACC_W]) begin
              acc_d = '1;
              sat_d = 1'b1;
            end else begin
              acc_d = sum_ext[ACC_W-1:0];
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == LenC) begin
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            // Result leaves while the next sum starts in the same cycle.
            if (accept) begin
              acc_d   = prod_ext;
              cnt_d   = 4'd1;
              state_d = (LEN == 1) ? StHold : StAccum;
            end
          end
        end
        default: begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_pm_accum.sv
// Bench for pm_accum: a 12-bit and a 9-bit instance share one stimulus stream and are
// compared every cycle against a sum-of-products reference model.
module tb_pm_accum;

  localparam int unsigned LEN   = 4;
  localparam int          MAX_A = 4095;
  localparam int          MAX_B = 511;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       d_valid;
  logic [7:0] d_prod;
  logic       d_oready;
  logic       d_clear;

  pm_accum_if #(.ACC_W(12)) bus_a ();
  pm_accum_if #(.ACC_W(9))  bus_b ();

  assign bus_a.prod_in    = d_prod;
  assign bus_a.prod_valid = d_valid;
  assign bus_a.out_ready  = d_oready;
  assign bus_a.clear      = d_clear;
  assign bus_b.prod_in    = d_prod;
  assign bus_b.prod_valid = d_valid;
  assign bus_b.out_ready  = d_oready;
  assign bus_b.clear      = d_clear;

  pm_accum #(.ACC_W(12), .LEN(LEN)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  pm_accum #(.ACC_W(9),  .LEN(LEN)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int checks   = 0;
  int failures = 0;

  // Reference model: exact running total of the products in the current set.
  int m_sum;
  int m_n;
  bit m_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int s, input int mx);
    return (s > mx) ? mx : s;
  endfunction

  task automatic model_reset();
    m_sum  = 0;
    m_n    = 0;
    m_hold = 0;
  endtask

  task automatic model_step();
    bit take;
    if (d_clear) begin
      model_reset();
    end else begin
      take = d_valid && (!m_hold || d_oready);
      if (m_hold && d_oready) model_reset();
      if (take) begin
        m_sum += int'(d_prod);
        m_n++;
        if (m_n == LEN) m_hold = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic exp_ready;
    exp_ready = !m_hold || d_oready;
    chk({tag, ".a.prod_ready"}, 32'(bus_a.prod_ready), 32'(exp_ready));
    chk({tag, ".b.prod_ready"}, 32'(bus_b.prod_ready), 32'(exp_ready));
    chk({tag, ".a.acc_valid"},  32'(bus_a.acc_valid),  32'(m_hold));
    chk({tag, ".b.acc_valid"},  32'(bus_b.acc_valid),  32'(m_hold));
    chk({tag, ".a.sat"},        32'(bus_a.sat),        32'(m_sum > MAX_A));
    chk({tag, ".b.sat"},        32'(bus_b.sat),        32'(m_sum > MAX_B));
    // Running sum in ACCUM is not a defined output, so only IDLE and HOLD are compared.
    if (m_hold) begin
      chk({tag, ".a.acc_out"}, 32'(bus_a.acc_out), 32'(clip(m_sum, MAX_A)));
      chk({tag, ".b.acc_out"}, 32'(bus_b.acc_out), 32'(clip(m_sum, MAX_B)));
    end else if (m_n == 0) begin
      chk({tag, ".a.acc_out"}, 32'(bus_a.acc_out), 32'd0);
      chk({tag, ".b.acc_out"}, 32'(bus_b.acc_out), 32'd0);
    end
  endtask

  // Entered at a falling edge: drive, check before the rising edge, advance the model.
  task automatic cycle(input string tag, input bit v, input logic [7:0] p,
                       input bit ordy, input bit clr);
    d_valid  = v;
    d_prod   = p;
    d_oready = ordy;
    d_clear  = clr;
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] set_a [4];
    rst_n    = 1'b0;
    d_valid  = 1'b0;
    d_prod   = 8'd0;
    d_oready = 1'b1;
    d_clear  = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_reset", 0, 8'd0, 1, 0);

    // 10,20,30,40 back to back.
    cycle("s29_p0", 1, 8'd10, 1, 0);
    cycle("s29_p1", 1, 8'd20, 1, 0);
    cycle("s29_p2", 1, 8'd30, 1, 0);
    cycle("s29_p3", 1, 8'd40, 1, 0);
    #1;
    chk("s29_sum",   32'(bus_a.acc_out),   32'd100);
    chk("s29_valid", 32'(bus_a.acc_valid), 32'd1);
    chk("s29_sat",   32'(bus_a.sat),       32'd0);
    cycle("s29_out", 0, 8'd0, 1, 0);
    #1;
    chk("s29_one_cycle", 32'(bus_a.acc_valid), 32'd0);

    // 225 x4 with bubbles: 900 fits in 12 bits, clips to 511 in 9 bits.
    for (int i = 0; i < 4; i++) begin
      cycle("s30_p", 1, 8'd225, 1, 0);
      cycle("s30_bub", 0, 8'd99, 1, 0);
    end
    // The bubbles above consumed the result; rebuild it without bubbles at the end.
    for (int i = 0; i < 4; i++) begin
      cycle("s30_q", 1, 8'd225, 0, 0);
      if (i < 3) cycle("s30_bub2", 0, 8'd1, 0, 0);
    end
    #1;
    chk("s30_a_sum", 32'(bus_a.acc_out), 32'd900);
    chk("s30_a_sat", 32'(bus_a.sat),     32'd0);
    chk("s30_b_sum", 32'(bus_b.acc_out), 32'd511);
    chk("s30_b_sat", 32'(bus_b.sat),     32'd1);

    // Held result with out_ready=0 and a waiting product.
    for (int i = 0; i < 5; i++) begin
      cycle("s31_hold", 1, 8'd7, 0, 0);
      chk("s31_stable", 32'(bus_a.acc_out), 32'd900);
    end
    cycle("s31_release", 1, 8'd7, 1, 0);
    #1;
    chk("s31_valid_drop", 32'(bus_a.acc_valid), 32'd0);
    cycle("s31_p1", 1, 8'd1, 1, 0);
    cycle("s31_p2", 1, 8'd1, 1, 0);
    cycle("s31_p3", 1, 8'd1, 0, 0);
    #1;
    chk("s31_next_sum", 32'(bus_a.acc_out), 32'd10);
    cycle("s31_drain", 0, 8'd0, 1, 0);

    // Back-to-back sets 1..4 and 5..8.
    for (int i = 0; i < 8; i++) begin
      cycle("s32_p", 1, 8'(i + 1), 1, 0);
      if (i == 3) chk("s32_first", 32'(bus_a.acc_out), 32'd10);
    end
    #1;
    chk("s32_second", 32'(bus_a.acc_out), 32'd26);
    chk("s32_b_second", 32'(bus_b.acc_out), 32'd26);
    cycle("s32_drain", 0, 8'd0, 1, 0);

    // Abort after two products, including a same-cycle product, then 1,1,1,1.
    cycle("s33_p0", 1, 8'd50, 1, 0);
    cycle("s33_p1", 1, 8'd60, 1, 0);
    cycle("s33_clr", 1, 8'd9, 1, 1);
    for (int i = 0; i < 4; i++) cycle("s33_one", 1, 8'd1, 0, 0);
    #1;
    chk("s33_sum", 32'(bus_a.acc_out), 32'd4);

    // Clear while holding drops the result.
    cycle("s33_clr_hold", 0, 8'd0, 0, 1);
    #1;
    chk("s33_clr_valid", 32'(bus_a.acc_valid), 32'd0);

    // Reset asynchronously while holding a saturated result.
    set_a = '{8'd200, 8'd200, 8'd200, 8'd200};
    for (int i = 0; i < 4; i++) cycle("s33_fill", 1, set_a[i], 0, 0);
    #1;
    chk("s33_pre_rst_valid", 32'(bus_b.acc_valid), 32'd1);
    chk("s33_pre_rst_sat",   32'(bus_b.sat),       32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s33_rst_valid", 32'(bus_a.acc_valid), 32'd0);
    chk("s33_rst_out",   32'(bus_a.acc_out),   32'd0);
    chk("s33_rst_b_sat", 32'(bus_b.sat),       32'd0);
    check_outputs("s33_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle("s33_after", 1, 8'(i + 3), 0, 0);
    #1;
    chk("s33_after_sum", 32'(bus_a.acc_out), 32'd18);
    cycle("s33_after_drain", 0, 8'd0, 1, 0);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
